// File: rtl/pll_data_separator.sv
// Digital PLL data separator: synchronises flux pulses, frames them into bit windows and tracks
// phase. The optional lock detector is built only when PLL_DSEP_LOCK_DETECT_EN is defined.
module pll_data_separator #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned DEFAULT_PERIOD = 16,
  parameter int unsigned GAIN_SHIFT     = 2,
  parameter int unsigned LOCK_TOL       = 1,
  parameter int unsigned LOCK_COUNT     = 8
) (
  input  logic                    MASTER_CLK,
  input  logic                    nRESET,
  input  logic                    FD_RDDATA_IN,
  input  logic                    ENABLE,
  input  logic                    MODE,
  input  logic [CNT_W-1:0]        CELL_PERIOD,
  output logic                    SHAPED_DATA,
  output logic                    DWIN,
  output logic                    BIT_VALID,
  output logic                    DATA_BIT,
  output logic signed [CNT_W:0]   PHASE_ERR,
  output logic                    LOCKED
);

  logic                  sync1_q, sync2_q, sync3_q, shaped_q;
  logic [CNT_W-1:0]      period_q, cnt_q, cnt_d, period_ld, center, last_cnt;
  logic                  dwin_q, bv_q, db_q, seen_q, wrap;
  logic signed [CNT_W:0] err_q, err_new;
  logic signed [CNT_W+1:0] prop_raw;

  assign center    = period_q >> 1;
  assign last_cnt  = period_q - CNT_W'(1);
  assign period_ld = (CELL_PERIOD < CNT_W'(4)) ? CNT_W'(4) : CELL_PERIOD;
  assign wrap      = ENABLE && (cnt_q == last_cnt);
  assign err_new   = $signed({1'b0, cnt_q}) - $signed({1'b0, center});
  assign prop_raw  = $signed({2'b00, cnt_q}) + $signed((CNT_W+2)'(1))
                   - $signed((CNT_W+2)'(err_new >>> GAIN_SHIFT));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!ENABLE || wrap) begin
      cnt_d = '0;
    end else if (shaped_q) begin
      if (!MODE) begin
        cnt_d = center + CNT_W'(1);
      end else if (prop_raw[CNT_W+1]) begin
        cnt_d = '0;
      end else if (prop_raw > $signed({2'b00, last_cnt})) begin
        cnt_d = last_cnt;
      end else begin
        cnt_d = prop_raw[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge MASTER_CLK or negedge nRESET) begin
    if (!nRESET) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      shaped_q <= 1'b0;
      cnt_q    <= '0;
      period_q <= CNT_W'(DEFAULT_PERIOD);
      dwin_q   <= 1'b0;
      bv_q     <= 1'b0;
      db_q     <= 1'b0;
      seen_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      sync1_q  <= FD_RDDATA_IN;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      shaped_q <= sync2_q & ~sync3_q;
      cnt_q    <= cnt_d;
      if (!ENABLE) begin
        // Keep the period tracking the input so a restart uses it at once.
        dwin_q   <= 1'b0;
        bv_q     <= 1'b0;
        seen_q   <= 1'b0;
        period_q <= period_ld;
      end else begin
        bv_q <= wrap;
        if (shaped_q) err_q <= err_new;
        if (wrap) begin
          dwin_q   <= ~dwin_q;
          db_q     <= seen_q | shaped_q;
          seen_q   <= 1'b0;
          period_q <= period_ld;
        end else if (shaped_q) begin
          seen_q <= 1'b1;
        end
      end
    end
  end

  assign SHAPED_DATA = shaped_q;
  assign DWIN        = dwin_q;
  assign BIT_VALID   = bv_q;
  assign DATA_BIT    = db_q;
  assign PHASE_ERR   = err_q;

`ifdef PLL_DSEP_LOCK_DETECT_EN
  localparam int unsigned LockW   = $clog2(LOCK_COUNT + 1);
  localparam int          LockTol = int'(LOCK_TOL);

  logic [LockW-1:0] lock_q;
  logic             in_lock;

  assign in_lock = (err_new >= -LockTol) && (err_new <= LockTol);

  always_ff @(posedge MASTER_CLK or negedge nRESET) begin
    if (!nRESET) begin
      lock_q <= '0;
    end else if (!ENABLE) begin
      lock_q <= '0;
    end else if (shaped_q) begin
      if (!in_lock) begin
        lock_q <= '0;
      end else if (lock_q != LockW'(LOCK_COUNT)) begin
        lock_q <= lock_q + LockW'(1);
      end
    end
  end

  assign LOCKED = (lock_q == LockW'(LOCK_COUNT));
`else
  assign LOCKED = 1'b0;
`endif

endmodule

// File: tb/tb_pll_data_separator.sv
// Bench for pll_data_separator: directed scenarios plus random flux traffic, all outputs
// compared every cycle against a window-level integer model of the separator.
module tb_pll_data_separator;

  localparam int GS  = 1;
  localparam int TOL = 1;
  localparam int LC  = 8;
  localparam int DEF = 16;

  logic       clk = 1'b0;
  logic       nrst, fd, en, mode;
  logic [7:0] cp;
  logic       shaped, dwin, bv, db, locked;
  logic signed [8:0] perr;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_p, m_cnt, m_err, m_lock;
  bit m_dwin, m_bv, m_db, m_seen, m_shaped;
  bit hist[$];

  always #5 clk = ~clk;

  pll_data_separator #(
    .CNT_W(8), .DEFAULT_PERIOD(DEF), .GAIN_SHIFT(GS), .LOCK_TOL(TOL), .LOCK_COUNT(LC)
  ) dut (
    .MASTER_CLK  (clk),
    .nRESET      (nrst),
    .FD_RDDATA_IN(fd),
    .ENABLE      (en),
    .MODE        (mode),
    .CELL_PERIOD (cp),
    .SHAPED_DATA (shaped),
    .DWIN        (dwin),
    .BIT_VALID   (bv),
    .DATA_BIT    (db),
    .PHASE_ERR   (perr),
    .LOCKED      (locked)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p = DEF; m_cnt = 0; m_err = 0; m_lock = 0;
    m_dwin = 0; m_bv = 0; m_db = 0; m_seen = 0; m_shaped = 0;
    hist = '{0, 0, 0};
  endtask

  function automatic int exp_locked();
`ifdef PLL_DSEP_LOCK_DETECT_EN
    return (m_lock == LC) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // One clock of the separator's rules, evaluated on the inputs about to be sampled.
  task automatic model_step();
    bit sh, wrap;
    int c, ld, nx;
    sh = m_shaped;
    hist.push_back(fd);
    m_shaped = (hist[1] == 1'b1) && (hist[0] == 1'b0);
    void'(hist.pop_front());
    c  = m_p / 2;
    ld = (int'(cp) < 4) ? 4 : int'(cp);
    if (!en) begin
      m_cnt = 0; m_dwin = 0; m_bv = 0; m_lock = 0; m_seen = 0; m_p = ld;
    end else begin
      wrap = (m_cnt == m_p - 1);
      if (sh) begin
        m_err = m_cnt - c;
        if (m_err >= -TOL && m_err <= TOL) m_lock = (m_lock < LC) ? m_lock + 1 : LC;
        else m_lock = 0;
      end
      m_bv = wrap;
      if (wrap) begin
        m_cnt = 0; m_dwin = !m_dwin; m_db = m_seen | sh; m_seen = 0; m_p = ld;
      end else if (sh) begin
        m_seen = 1;
        if (mode) begin
          nx = m_cnt + 1 - (m_err >>> GS);
          if (nx < 0) nx = 0;
          if (nx > m_p - 1) nx = m_p - 1;
        end else begin
          nx = c + 1;
        end
        m_cnt = nx;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic compare();
    chk("shaped", shaped, m_shaped);
    chk("dwin", dwin, m_dwin);
    chk("bit_valid", bv, m_bv);
    if (m_bv) chk("data_bit", db, m_db);
    chk("phase_err", perr, m_err);
    chk("locked", locked, exp_locked());
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic wait_bv(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bv && n < 300);
  endtask

  // Raise the flux input so the shaped pulse lands while the window counter equals t.
  task automatic edge_at(input int t);
    for (int i = 0; i < 200 && m_cnt != t - 3; i++) step();
    fd = 1'b1;
    step();
    step();
    fd = 1'b0;
    step();
    chk("shaped_at_target", shaped, 1);
    step();
  endtask

  initial begin
    int n, hi_left, lo_left;
    nrst = 1'b0; fd = 1'b0; en = 1'b0; mode = 1'b0; cp = 8'd16;
    model_reset();
    #2;
    chk("rst_shaped", shaped, 0);
    chk("rst_dwin", dwin, 0);
    chk("rst_bv", bv, 0);
    chk("rst_db", db, 0);
    chk("rst_err", perr, 0);
    chk("rst_locked", locked, 0);
    #10;
    nrst = 1'b1;
    en   = 1'b1;

    // Free-running windows with no flux.
    wait_bv(n);
    chk("idle_win1", n, 16);
    chk("idle_db1", db, 0);
    wait_bv(n);
    chk("idle_win2", n, 16);
    chk("idle_dwin", dwin, 0);

    // Hard realign.
    edge_at(11);
    chk("m0_err", perr, 3);
    wait_bv(n);
    chk("m0_next_cnt", n, 16 - 9);
    chk("m0_db", db, 1);

    // Proportional correction.
    mode = 1'b1;
    edge_at(12);
    chk("m1_err_pos", perr, 4);
    wait_bv(n);
    chk("m1_next_pos", n, 16 - 11);
    edge_at(4);
    chk("m1_err_neg", perr, -4);
    wait_bv(n);
    chk("m1_next_neg", n, 16 - 7);

    // Lock acquisition and loss.
    mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edge_at(8);
      chk("lock_err", perr, 0);
`ifdef PLL_DSEP_LOCK_DETECT_EN
      chk("lock_rise", locked, (i >= 7) ? 1 : 0);
`else
      chk("lock_off", locked, 0);
`endif
    end
    edge_at(13);
    chk("unlock_err", perr, 5);
    chk("unlock", locked, 0);

    // Edge on the wrap cycle.
    edge_at(15);
    chk("wrap_bv", bv, 1);
    chk("wrap_db", db, 1);
    chk("wrap_err", perr, 7);
    wait_bv(n);
    chk("wrap_next", n, 16);

    // Period change mid-window.
    for (int i = 0; i < 5; i++) step();
    cp = 8'd20;
    wait_bv(n);
    chk("per_cur", n, 11);
    wait_bv(n);
    chk("per_next", n, 20);

    // Asynchronous reset mid-window with a pending flux pulse.
    for (int i = 0; i < 3; i++) step();
    fd = 1'b1;
    step();
    nrst = 1'b0;
    fd   = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_shaped", shaped, 0);
    chk("mid_rst_dwin", dwin, 0);
    chk("mid_rst_bv", bv, 0);
    chk("mid_rst_db", db, 0);
    chk("mid_rst_err", perr, 0);
    chk("mid_rst_locked", locked, 0);
    #2;
    nrst = 1'b1;
    wait_bv(n);
    chk("post_rst_win", n, DEF);
    chk("post_rst_db", db, 0);

    // Enable restart reloads the period immediately.
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    cp = 8'd8;
    step();
    en = 1'b1;
    wait_bv(n);
    chk("restart_win", n, 8);
    cp = 8'd16;

    // Random traffic.
    hi_left = 0;
    lo_left = 5;
    for (int i = 0; i < 3000; i++) begin
      if (hi_left > 0) begin
        fd = 1'b1; hi_left--;
      end else if (lo_left > 0) begin
        fd = 1'b0; lo_left--;
      end else begin
        fd = 1'b1;
        hi_left = $urandom_range(1, 3);
        lo_left = $urandom_range(2, 30);
      end
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 99) == 0) cp = 8'($urandom_range(0, 24));
      if ($urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
